ghost_io_bank: RTL and testbench
================================

Name: ghost_io_bank

Overview:
- Parametrised, multi-channel successor to the single ghost direction/status PIO pair on the NIOS SoC.
- Avalon-MM slave bank that gives each of NUM_GHOSTS ghosts:
  - a software-written direction register, driven to the ghost FSMs;
  - a synchronised, read-only status register.
- Status changes are detected per ghost, latched as pending bits, and raised as one maskable interrupt to the CPU.
- Sits between the Qsys interconnect and the ghost movement logic in the top level.

Parameters:
- NUM_GHOSTS, 4, number of ghost channels (1..8).
- DIR_W, 16, direction register width per ghost (1..32).
- STAT_W, 16, status input width per ghost (1..32).
- ADDR_W, 4, word address width. Must satisfy 2^ADDR_W >= 2*NUM_GHOSTS+2, or 3*NUM_GHOSTS+2 when the timestamp feature is compiled in.
- DIR_RESET, 0, reset value loaded into every direction register.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed latency 1.
- ghost_direction  out  NUM_GHOSTS*DIR_W  flattened direction registers; ghost i occupies bits [i*DIR_W +: DIR_W].
- ghost_status  in  NUM_GHOSTS*STAT_W  flattened, asynchronous status inputs from the ghost FSMs.
- irq  out  1  level interrupt.

Behaviour:
- Reset (asynchronous, active-low): every output takes its reset value immediately, independent of clk_clk.
  - Direction registers = DIR_RESET.
  - Sync flops, status snapshot, pending and mask = 0.
  - avs_readdata = 0, irq = 0.
- Register map, word offsets:
  - 0..N-1: DIR[i], read/write.
  - N..2N-1: STAT[i], read-only.
  - 2N: IRQ_PEND, write-1-to-clear, bits [N-1:0].
  - 2N+1: IRQ_MASK, read/write, bits [N-1:0].
  - All other offsets read 0; writes to them are ignored.
- Write: when chipselect & write, the target register updates on that clock edge.
  - DIR writes take the low DIR_W bits of writedata.
  - ghost_direction reflects a write one cycle after the write strobe.
  - Writes to STAT are ignored.
- Read: when chipselect & read, avs_readdata is registered on that edge and valid the next cycle.
  - Values are zero-extended to 32 bits.
  - avs_readdata holds its value until the next read.
- Status path, per ghost:
  - Two-flop synchroniser, then a snapshot register stat_q.
  - Change detect: if sync_out != stat_q, stat_q <= sync_out and pend[i] <= 1.
  - Latency from an input change to a visible pend bit: 3 clk_clk edges.
- IRQ_PEND W1C: pend[i] clears where writedata[i] = 1.
  - If a new change and a W1C of the same bit occur in the same cycle, the set wins and pend stays 1.
- irq = registered OR of (pend & mask); it updates one cycle after pend or mask changes.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- All counters and registers wrap naturally; no saturation is applied.

Optional Feature:
- Macro: GHOST_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter runs from reset and wraps at 2^32.
  - Each detected status change latches that cycle's counter value into TS[i].
  - TS[i] is read-only at offsets 2N+2..3N+1.
- When undefined: no counter or TS registers are built, and offsets 2N+2..3N+1 read 0.

Test Plan:
- Reset: hold reset_reset_n low mid-transaction.
  - Required: ghost_direction = DIR_RESET on every channel, irq = 0.
  - Required: reads of all offsets return 0, except DIR offsets, which return DIR_RESET.
- Direction write/readback: write 0x0000_0003 to offset 2 (ghost 2).
  - Required: ghost_direction[47:32] = 0x0003 one cycle later.
  - Required: a read of offset 2 returns 0x0000_0003 one cycle after the read strobe.
- Status change and interrupt: with IRQ_MASK = 0x2, drive ghost_status[31:16] from 0x0000 to 0x00A5.
  - Required: STAT[1] (offset 5) reads 0x000000A5.
  - Required: IRQ_PEND = 0x2 after 3 edges, and irq = 1 one edge later.
- W1C versus new set: write 0x2 to IRQ_PEND in the same cycle a second ghost 1 change is detected.
  - Required: pend[1] remains 1 and irq stays high.
  - Required: a later isolated W1C of 0x2 clears pend[1], and irq drops the next cycle.
- Mask gating and unmapped access: change ghost 0 status with IRQ_MASK = 0.
  - Required: IRQ_PEND = 0x1 and irq stays 0.
  - Required: writing IRQ_MASK = 0x1 raises irq one cycle later.
  - Required: a read of offset 15 returns 0.
- Timestamp, with GHOST_TIMESTAMP_EN: change ghost 3 status at counter value C.
  - Required: TS[3] (offset 13) reads C + 2, the value at the detecting edge.
  - Required: without the macro, offset 13 reads 0.

Source files
------------

// File: rtl/ghost_io_bank.sv
// ghost_io_bank: Avalon-MM register bank for NUM_GHOSTS ghost channels.
// Each ghost has a software-written direction register and a synchronised,
// read-only status snapshot. Status changes latch per-ghost pending bits,
// which are masked and ORed into a single registered interrupt.
// Optional build macro GHOST_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter and per-ghost TS registers capturing the count at each detected
// status change. These TS registers are read at offsets 2N+2..3N+1.
module ghost_io_bank #(
   parameter int NUM_GHOSTS = 4,
   parameter int DIR_W      = 16,
   parameter int STAT_W     = 16,
   parameter int ADDR_W     = 4,
   parameter logic [DIR_W-1:0] DIR_RESET = '0
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset_n,
   input  logic [ADDR_W-1:0]            avs_address,
   input  logic                         avs_chipselect,
   input  logic                         avs_read,
   input  logic                         avs_write,
   input  logic [31:0]                  avs_writedata,
   output logic [31:0]                  avs_readdata,
   output logic [NUM_GHOSTS*DIR_W-1:0]  ghost_direction,
   input  logic [NUM_GHOSTS*STAT_W-1:0] ghost_status,
   output logic                         irq
);

   localparam int STAT_OFF = NUM_GHOSTS;
   localparam int PEND_OFF = 2 * NUM_GHOSTS;
   localparam int MASK_OFF = 2 * NUM_GHOSTS + 1;
`ifdef GHOST_TIMESTAMP_EN
   localparam int TS_OFF   = 2 * NUM_GHOSTS + 2;
`endif

   logic                         wr_en;
   logic                         rd_en;
   logic [NUM_GHOSTS*DIR_W-1:0]  dir_flat;
   logic [NUM_GHOSTS*STAT_W-1:0] stat_flat;
   logic [NUM_GHOSTS-1:0]        chg;
   logic [NUM_GHOSTS-1:0]        pend_q, pend_d;
   logic [NUM_GHOSTS-1:0]        mask_q, mask_d;
   logic                         irq_q, irq_d;
   logic [31:0]                  rdata_q, rdata_d;

   // Upper write-data bits are only consumed for wide DIR_W configurations.
   logic unused_wdata;
   assign unused_wdata = ^avs_writedata;

   assign wr_en           = avs_chipselect & avs_write;
   assign rd_en           = avs_chipselect & avs_read;
   assign ghost_direction = dir_flat;
   assign avs_readdata    = rdata_q;
   assign irq             = irq_q;

`ifdef GHOST_TIMESTAMP_EN
   logic [31:0]                  cnt_q, cnt_d;
   logic [NUM_GHOSTS*32-1:0]     ts_flat;

   // Free-running cycle counter, wraps naturally at 2^32.
   always_comb begin
      cnt_d = cnt_q + 32'd1;
   end

   // Cycle counter register.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) cnt_q <= '0;
      else                cnt_q <= cnt_d;
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
         logic [DIR_W-1:0]  dir_q,   dir_d;
         logic [STAT_W-1:0] sync1_q, sync1_d;
         logic [STAT_W-1:0] sync2_q, sync2_d;
         logic [STAT_W-1:0] stat_q,  stat_d;
         logic              chg_w;
`ifdef GHOST_TIMESTAMP_EN
         logic [31:0]       ts_q,    ts_d;
`endif

         // Direction write decode, status synchroniser and change detect.
         always_comb begin
            dir_d   = dir_q;
            if (wr_en && (avs_address == ADDR_W'(gi)))
               dir_d = avs_writedata[DIR_W-1:0];
            sync1_d = ghost_status[gi*STAT_W +: STAT_W];
            sync2_d = sync1_q;
            chg_w   = (sync2_q != stat_q);
            stat_d  = chg_w ? sync2_q : stat_q;
`ifdef GHOST_TIMESTAMP_EN
            ts_d    = chg_w ? cnt_q : ts_q;
`endif
         end

         // Per-ghost state registers.
         always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
               dir_q   <= DIR_RESET;
               sync1_q <= '0;
               sync2_q <= '0;
               stat_q  <= '0;
`ifdef GHOST_TIMESTAMP_EN
               ts_q    <= '0;
`endif
            end else begin
               dir_q   <= dir_d;
               sync1_q <= sync1_d;
               sync2_q <= sync2_d;
               stat_q  <= stat_d;
`ifdef GHOST_TIMESTAMP_EN
               ts_q    <= ts_d;
`endif
            end
         end

         assign dir_flat[gi*DIR_W +: DIR_W]   = dir_q;
         assign stat_flat[gi*STAT_W +: STAT_W] = stat_q;
         assign chg[gi]                        = chg_w;
`ifdef GHOST_TIMESTAMP_EN
         assign ts_flat[gi*32 +: 32]           = ts_q;
`endif
      end
   endgenerate

   // Pending (W1C, set wins over clear), mask and interrupt next-state.
   always_comb begin
      pend_d = pend_q;
      if (wr_en && (avs_address == ADDR_W'(PEND_OFF)))
         pend_d = pend_q & ~avs_writedata[NUM_GHOSTS-1:0];
      pend_d = pend_d | chg;
      mask_d = mask_q;
      if (wr_en && (avs_address == ADDR_W'(MASK_OFF)))
         mask_d = avs_writedata[NUM_GHOSTS-1:0];
      irq_d  = |(pend_q & mask_q);
   end

   // Read mux: sampled from current register values, so a same-cycle
   // write to the addressed register is not visible until the next read.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = '0;
         for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (avs_address == ADDR_W'(i))
               rdata_d = 32'(dir_flat[i*DIR_W +: DIR_W]);
            if (avs_address == ADDR_W'(STAT_OFF + i))
               rdata_d = 32'(stat_flat[i*STAT_W +: STAT_W]);
`ifdef GHOST_TIMESTAMP_EN
            if (avs_address == ADDR_W'(TS_OFF + i))
               rdata_d = ts_flat[i*32 +: 32];
`endif
         end
         if (avs_address == ADDR_W'(PEND_OFF))
            rdata_d = 32'(pend_q);
         if (avs_address == ADDR_W'(MASK_OFF))
            rdata_d = 32'(mask_q);
      end
   end

   // Shared control and read-data registers.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pend_q  <= '0;
         mask_q  <= '0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ghost_io_bank.sv
// tb_ghost_io_bank: directed bench for ghost_io_bank with a read scoreboard.
// Reads push their expected data into a queue; a monitor pops and compares
// one cycle after each read strobe. Direct output checks run inline.
module tb_ghost_io_bank;

   localparam int N      = 4;
   localparam int DIR_W  = 16;
   localparam int STAT_W = 16;
   localparam int ADDR_W = 4;

   logic                     clk_clk = 1'b0;
   logic                     reset_reset_n;
   logic [ADDR_W-1:0]        avs_address;
   logic                     avs_chipselect;
   logic                     avs_read;
   logic                     avs_write;
   logic [31:0]              avs_writedata;
   logic [31:0]              avs_readdata;
   logic [N*DIR_W-1:0]       ghost_direction;
   logic [N*STAT_W-1:0]      ghost_status;
   logic                     irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   int          adr_q[$];
   logic        rd_seen = 1'b0;
   logic [31:0] tb_cnt;

   ghost_io_bank #(
      .NUM_GHOSTS(N), .DIR_W(DIR_W), .STAT_W(STAT_W), .ADDR_W(ADDR_W),
      .DIR_RESET(16'h0000)
   ) dut (
      .clk_clk(clk_clk),
      .reset_reset_n(reset_reset_n),
      .avs_address(avs_address),
      .avs_chipselect(avs_chipselect),
      .avs_read(avs_read),
      .avs_write(avs_write),
      .avs_writedata(avs_writedata),
      .avs_readdata(avs_readdata),
      .ghost_direction(ghost_direction),
      .ghost_status(ghost_status),
      .irq(irq)
   );

   always #5 clk_clk = ~clk_clk;

   // Reference cycle count: zero in reset, +1 on every edge afterwards.
   always @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) tb_cnt <= '0;
      else                tb_cnt <= tb_cnt + 32'd1;
   end

   // Monitor: note a read strobe at the edge, compare on the following negedge.
   always @(posedge clk_clk) begin
      rd_seen <= avs_chipselect && avs_read && reset_reset_n;
   end

   always @(negedge clk_clk) begin
      if (rd_seen) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected actual=%h (no expected entry)", avs_readdata);
         end else begin
            logic [31:0] e;
            int          a;
            e = exp_q.pop_front();
            a = adr_q.pop_front();
            if (avs_readdata !== e) begin
               failures++;
               $display("FAIL rd_off%0d actual=%h required=%h", a, avs_readdata, e);
            end else
               $display("read  off=%0d data=%h ok", a, avs_readdata);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else
         $display("check %s value=%h ok", name, act);
   endtask

   task automatic idle();
      avs_chipselect = 1'b0;
      avs_read       = 1'b0;
      avs_write      = 1'b0;
      avs_address    = '0;
      avs_writedata  = '0;
   endtask

   // Called at a negedge; drives a one-cycle strobe and returns at the next negedge.
   task automatic wr(input int adr, input logic [31:0] data);
      avs_chipselect = 1'b1;
      avs_write      = 1'b1;
      avs_address    = ADDR_W'(adr);
      avs_writedata  = data;
      $display("write off=%0d data=%h", adr, data);
      @(negedge clk_clk);
      idle();
   endtask

   task automatic rd(input int adr, input logic [31:0] expv);
      exp_q.push_back(expv);
      adr_q.push_back(adr);
      avs_chipselect = 1'b1;
      avs_read       = 1'b1;
      avs_address    = ADDR_W'(adr);
      @(negedge clk_clk);
      idle();
   endtask

   task automatic rdwr(input int adr, input logic [31:0] data, input logic [31:0] expv);
      exp_q.push_back(expv);
      adr_q.push_back(adr);
      avs_chipselect = 1'b1;
      avs_read       = 1'b1;
      avs_write      = 1'b1;
      avs_address    = ADDR_W'(adr);
      avs_writedata  = data;
      @(negedge clk_clk);
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] c_val;
      reset_reset_n = 1'b0;
      ghost_status  = '0;
      idle();
      repeat (3) @(negedge clk_clk);
      chk("rst_dir",   32'(ghost_direction[31:0]), 32'h0);
      chk("rst_irq",   32'(irq), 32'h0);
      chk("rst_rdata", avs_readdata, 32'h0);
      reset_reset_n = 1'b1;

      // Build up non-reset state, then reset in the middle of a write.
      wr(0, 32'h0000_AAAA);
      wr(9, 32'h1);
      ghost_status[15:0] = 16'h0001;
      repeat (5) @(negedge clk_clk);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      chk("pre_rst_dir0", 32'(ghost_direction[15:0]), 32'h0000_AAAA);
      avs_chipselect = 1'b1;
      avs_write      = 1'b1;
      avs_address    = 4'd1;
      avs_writedata  = 32'h5555;
      #2;
      reset_reset_n = 1'b0;
      ghost_status  = '0;
      #1;
      chk("async_rst_dir_lo", ghost_direction[31:0], 32'h0);
      chk("async_rst_dir_hi", ghost_direction[63:32], 32'h0);
      chk("async_rst_irq", 32'(irq), 32'h0);
      @(negedge clk_clk);
      idle();
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      for (int a = 0; a < 16; a++) rd(a, 32'h0);

      // Direction write and readback, including truncation to DIR_W.
      wr(2, 32'h0000_0003);
      chk("dir2_out", 32'(ghost_direction[47:32]), 32'h3);
      chk("dir_others", {ghost_direction[63:48], ghost_direction[31:16]}, 32'h0);
      rd(2, 32'h0000_0003);
      wr(0, 32'hDEAD_BEEF);
      chk("dir0_out", 32'(ghost_direction[15:0]), 32'h0000_BEEF);
      rd(0, 32'h0000_BEEF);

      // Status change on ghost 1 with mask 0x2: pend after 3 edges, irq after 4.
      wr(9, 32'h2);
      ghost_status[31:16] = 16'h00A5;
      @(negedge clk_clk);
      @(negedge clk_clk);
      rd(8, 32'h0);
      chk("irq_edge3", 32'(irq), 32'h0);
      rd(8, 32'h2);
      chk("irq_edge4", 32'(irq), 32'h1);
      rd(5, 32'h0000_00A5);
      wr(5, 32'hFFFF_FFFF);
      rd(5, 32'h0000_00A5);

      // W1C in the same cycle as a new ghost 1 change: set wins.
      ghost_status[31:16] = 16'h005A;
      @(negedge clk_clk);
      @(negedge clk_clk);
      wr(8, 32'h2);
      chk("w1c_race_irq_a", 32'(irq), 32'h1);
      @(negedge clk_clk);
      chk("w1c_race_irq_b", 32'(irq), 32'h1);
      rd(8, 32'h2);
      rd(5, 32'h0000_005A);
      wr(8, 32'h2);
      chk("w1c_irq_hold", 32'(irq), 32'h1);
      @(negedge clk_clk);
      chk("w1c_irq_drop", 32'(irq), 32'h0);
      rd(8, 32'h0);

      // Mask gating and unmapped read.
      wr(9, 32'h0);
      ghost_status[15:0] = 16'h0011;
      repeat (5) @(negedge clk_clk);
      chk("masked_irq", 32'(irq), 32'h0);
      rd(8, 32'h1);
      wr(9, 32'h1);
      chk("unmask_irq_0", 32'(irq), 32'h0);
      @(negedge clk_clk);
      chk("unmask_irq_1", 32'(irq), 32'h1);
      rd(15, 32'h0);
      rd(9, 32'h1);
      rd(4, 32'h0000_0011);

      // Simultaneous read and write returns the pre-write value.
      rdwr(2, 32'h0000_7777, 32'h0000_0003);
      rd(2, 32'h0000_7777);

      // Timestamp capture on ghost 3.
      c_val = tb_cnt;
      ghost_status[63:48] = 16'h0F0F;
      repeat (4) @(negedge clk_clk);
      rd(7, 32'h0000_0F0F);
`ifdef GHOST_TIMESTAMP_EN
      rd(13, c_val + 32'd2);
`else
      rd(13, 32'h0);
`endif

      repeat (3) @(negedge clk_clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
